// File: rtl/dff_en.sv
// dff_en -- enabled, clearable D flip-flop register with a configurable number
// of cascaded stages (an enabled shift chain). All stages share en and clr.
//
// Parameters:
//   WIDTH    data width of d/q in bits (>=1)
//   STAGES   register stages between d and q (>=1)
//   CLR_VAL  value loaded into every stage when clr is sampled high
//
// Ports:
//   clk  in   1      clock, rising edge only
//   clr  in   1      synchronous active-high clear, priority over en
//   en   in   1      capture/advance enable, active-high
//   d    in   WIDTH  data input
//   q    out  WIDTH  last stage of the chain (pure register output)
//   qn   out  WIDTH  ~q, only when the DFF_QN_EN macro is defined
//
// Optional feature macro: DFF_QN_EN (adds the qn port).
module dff_en #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      STAGES  = 1,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef DFF_QN_EN
    ,
    output logic [WIDTH-1:0] qn
`endif
);

    // Stage 0 occupies the low WIDTH bits; the last stage sits at the top.
    logic [STAGES*WIDTH-1:0] chain;
    logic [STAGES*WIDTH-1:0] chain_next;

    // Shifted image of the chain; a single stage has nothing to shift.
    generate
        if (STAGES > 1) begin : g_multi
            always_comb begin
                chain_next = {chain[(STAGES-1)*WIDTH-1:0], d};
            end
        end else begin : g_single
            always_comb begin
                chain_next = d;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            chain <= {STAGES{CLR_VAL}};
        end else if (en) begin
            chain <= chain_next;
        end
    end

    assign q = chain[STAGES*WIDTH-1 -: WIDTH];

`ifdef DFF_QN_EN
    // Inverted straight from the last stage register, so no path from d.
    assign qn = ~chain[STAGES*WIDTH-1 -: WIDTH];
`endif

endmodule

// File: tb/tb_dff_en.sv
module tb_dff_en;

    localparam logic       CLR1 = 1'b0;
    localparam logic [7:0] CLR3 = 8'hA5;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       d1;
    logic [7:0] d3;
    logic       q1;
    logic [7:0] q3;
`ifdef DFF_QN_EN
    logic       qn1;
    logic [7:0] qn3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference: pending data in each chain (oldest at front) and expected outputs.
    logic       p1[$];
    logic [7:0] p3[$];
    logic       e1q[$];
    logic [7:0] e3q[$];

    always #5 clk = ~clk;

    dff_en #(.WIDTH(1), .STAGES(1), .CLR_VAL(CLR1)) dut1 (
        .clk(clk), .clr(clr), .en(en), .d(d1), .q(q1)
`ifdef DFF_QN_EN
        , .qn(qn1)
`endif
    );

    dff_en #(.WIDTH(8), .STAGES(3), .CLR_VAL(CLR3)) dut3 (
        .clk(clk), .clr(clr), .en(en), .d(d3), .q(q3)
`ifdef DFF_QN_EN
        , .qn(qn3)
`endif
    );

    // Drive inputs for the coming edge and push the outputs expected after it.
    task automatic drive(input logic c, input logic e, input logic a, input logic [7:0] b);
        clr = c; en = e; d1 = a; d3 = b;
        if (c) begin
            p1.delete();
            p3.delete();
            p1.push_back(CLR1);
            for (int i = 0; i < 3; i++) p3.push_back(CLR3);
        end else if (e) begin
            p1.push_back(a);
            void'(p1.pop_front());
            p3.push_back(b);
            void'(p3.pop_front());
        end
        e1q.push_back(p1[0]);
        e3q.push_back(p3[0]);
    endtask

    task automatic apply(input logic c, input logic e, input logic a, input logic [7:0] b);
        @(negedge clk);
        drive(c, e, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic e1;
        logic [7:0] e3;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        e1 = e1q.pop_front(); e3 = e3q.pop_front();
        n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL reset q1: got %b want %b", q1, e1); end
        n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL reset q3: got %h want %h", q3, e3); end
`ifdef DFF_QN_EN
        n_cmp++; if (qn1 !== ~e1) begin n_err++; $display("FAIL reset qn1: got %b want %b", qn1, ~e1); end
        n_cmp++; if (qn3 !== ~e3) begin n_err++; $display("FAIL reset qn3: got %h want %h", qn3, ~e3); end
`endif
    endtask

    task automatic test_capture();
        logic dv[3] = '{1'b1, 1'b0, 1'b1};
        logic e1;
        logic [7:0] e3;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, dv[i], 8'($urandom));
            e1 = e1q.pop_front(); e3 = e3q.pop_front();
            n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL capture q1 cyc %0d: got %b want %b", i, q1, e1); end
            n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL capture q3 cyc %0d: got %h want %h", i, q3, e3); end
        end
    endtask

    task automatic test_hold();
        logic e1;
        logic [7:0] e3;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 8'($urandom));
            e1 = e1q.pop_front(); e3 = e3q.pop_front();
            n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL hold q1 cyc %0d: got %b want %b", i, q1, e1); end
            n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL hold q3 cyc %0d: got %h want %h", i, q3, e3); end
        end
    endtask

    task automatic test_clr_between();
        logic h1;
        logic [7:0] h3;
        logic e1;
        logic [7:0] e3;
        h1 = p1[0];
        h3 = p3[0];
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 8'h3C);
        #3;
        n_cmp++; if (q1 !== h1) begin n_err++; $display("FAIL clr_mid q1: got %b want %b", q1, h1); end
        n_cmp++; if (q3 !== h3) begin n_err++; $display("FAIL clr_mid q3: got %h want %h", q3, h3); end
        @(posedge clk);
        #1;
        e1 = e1q.pop_front(); e3 = e3q.pop_front();
        n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL clr_edge q1: got %b want %b", q1, e1); end
        n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL clr_edge q3: got %h want %h", q3, e3); end
        for (int i = 0; i < 2; i++) begin
            apply(i == 0, 1'b0, 1'b1, 8'hC3);
            e1 = e1q.pop_front(); e3 = e3q.pop_front();
            n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL clr_stay q1 cyc %0d: got %b want %b", i, q1, e1); end
            n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL clr_stay q3 cyc %0d: got %h want %h", i, q3, e3); end
        end
    endtask

    task automatic test_clr_priority();
        logic       tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] td[5] = '{8'h11, 8'h22, 8'hFF, 8'h33, 8'h44};
        logic e1;
        logic [7:0] e3;
        for (int i = 0; i < 5; i++) begin
            apply(tc[i], 1'b1, 1'b1, td[i]);
            e1 = e1q.pop_front(); e3 = e3q.pop_front();
            n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL clr_prio q1 cyc %0d: got %b want %b", i, q1, e1); end
            n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL clr_prio q3 cyc %0d: got %h want %h", i, q3, e3); end
        end
    endtask

    task automatic test_stages();
        logic e1;
        logic [7:0] e3;
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, 1'($urandom_range(0, 1)), 1'($urandom), 8'($urandom));
            e1 = e1q.pop_front(); e3 = e3q.pop_front();
            n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL stages q1 cyc %0d: got %b want %b", i, q1, e1); end
            n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL stages q3 cyc %0d: got %h want %h", i, q3, e3); end
`ifdef DFF_QN_EN
            n_cmp++; if (qn1 !== ~e1) begin n_err++; $display("FAIL stages qn1 cyc %0d: got %b want %b", i, qn1, ~e1); end
            n_cmp++; if (qn3 !== ~e3) begin n_err++; $display("FAIL stages qn3 cyc %0d: got %h want %h", i, qn3, ~e3); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic e1;
        logic [7:0] e3;
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 1'(i), 8'(i * 17 + 1));
            e1 = e1q.pop_front(); e3 = e3q.pop_front();
            n_cmp++; if (q1 !== e1) begin n_err++; $display("FAIL b2b q1 cyc %0d: got %b want %b", i, q1, e1); end
            n_cmp++; if (q3 !== e3) begin n_err++; $display("FAIL b2b q3 cyc %0d: got %h want %h", i, q3, e3); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_capture();
        test_hold();
        test_clr_between();
        test_clr_priority();
        test_stages();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
